// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//
// Song-position timebase. A free-running divider counts CLKS_PER_SEMI clocks
// per semiquaver. Four semiquavers make a crotchet. The song is NUM_CROTCHETS
// crotchets long. Every output comes straight from a flop.
//
// Optional feature (macro BEAT_SEQUENCER_LOOP_EN):
//   defined   : after the last semiquaver of the last crotchet, wrap to
//               crotchet 0 with both strobes and keep running.
//   undefined : stop in DONE with crotchet = NUM_CROTCHETS-1 and semi = 3.
//
// Parameters
//   CLKS_PER_SEMI  clocks per semiquaver (2 .. 2^24-1)
//   NUM_CROTCHETS  song length in crotchets (2 .. 128)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle request to begin at crotchet 0 (IDLE/DONE only)
//   stop           one-cycle abort back to IDLE; wins over start and hold
//   hold           level; freezes divider, semi and crotchet while high
//   crotchet[6:0]  current crotchet index
//   crotchet_pulse one-cycle strobe with each new crotchet value
//   semi[1:0]      semiquaver within the crotchet
//   semi_pulse     one-cycle strobe with each new semi value
//   running        high in RUN or HOLD
//   done           high in DONE
//   state_dbg[1:0] FSM state (IDLE=0, RUN=1, HOLD=2, DONE=3) for checkers
//
// Handshake: start and stop are plain single-cycle requests sampled on the
// rising edge with no acknowledge; hold is a level sampled every edge.
// -----------------------------------------------------------------------------
module beat_sequencer #(
  parameter int CLKS_PER_SEMI = 5460000,
  parameter int NUM_CROTCHETS = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [6:0] crotchet,
  output logic       crotchet_pulse,
  output logic [1:0] semi,
  output logic       semi_pulse,
  output logic       running,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam logic [23:0] DIV_LAST      = 24'(CLKS_PER_SEMI - 1);
  localparam logic [6:0]  LAST_CROTCHET = 7'(NUM_CROTCHETS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [23:0] divider, divider_n;
  logic [6:0]  crotchet_n;
  logic [1:0]  semi_n;
  logic        crotchet_pulse_n, semi_pulse_n;
  logic        running_n, done_n;

  // Next-state and next-output logic.
  always_comb begin
    state_n          = state;
    divider_n        = divider;
    semi_n           = semi;
    crotchet_n       = crotchet;
    crotchet_pulse_n = 1'b0;
    semi_pulse_n     = 1'b0;

    if (stop) begin
      state_n    = IDLE;
      divider_n  = '0;
      semi_n     = '0;
      crotchet_n = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n          = RUN;
            divider_n        = '0;
            semi_n           = '0;
            crotchet_n       = '0;
            crotchet_pulse_n = 1'b1;
            semi_pulse_n     = 1'b1;
          end
        end
        RUN, HOLD: begin
          if (hold) begin
            // Everything stays frozen, including on the RUN->HOLD edge.
            state_n = HOLD;
          end else begin
            // Leaving HOLD counts on the same edge so a hold of N cycles
            // delays the timeline by exactly N cycles.
            state_n = RUN;
            if (divider == DIV_LAST) begin
              divider_n = '0;
              if (semi == 2'd3) begin
                if (crotchet == LAST_CROTCHET) begin
`ifdef BEAT_SEQUENCER_LOOP_EN
                  crotchet_n       = '0;
                  semi_n           = '0;
                  crotchet_pulse_n = 1'b1;
                  semi_pulse_n     = 1'b1;
`else
                  // End of song: crotchet and semi keep their last values.
                  state_n = DONE;
`endif
                end else begin
                  crotchet_n       = crotchet + 7'd1;
                  semi_n           = '0;
                  crotchet_pulse_n = 1'b1;
                  semi_pulse_n     = 1'b1;
                end
              end else begin
                semi_n       = semi + 2'd1;
                semi_pulse_n = 1'b1;
              end
            end else begin
              divider_n = divider + 24'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    running_n = (state_n == RUN) || (state_n == HOLD);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      divider        <= '0;
      semi           <= '0;
      crotchet       <= '0;
      crotchet_pulse <= 1'b0;
      semi_pulse     <= 1'b0;
      running        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      divider        <= divider_n;
      semi           <= semi_n;
      crotchet       <= crotchet_n;
      crotchet_pulse <= crotchet_pulse_n;
      semi_pulse     <= semi_pulse_n;
      running        <= running_n;
      done           <= done_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/beat_sequencer.md
BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_SEMI, default 5460000, clocks per semiquaver (range 2..2^24-1).
REQ-002 SHALL have parameter NUM_CROTCHETS, default 104 (13 phrases x 8), song length in crotchets (2..128).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin the song from crotchet 0.
REQ-006 SHALL have port stop  input  1  single-cycle request to abort and return to idle.
REQ-007 SHALL have port hold  input  1  level; freezes timing while high in RUN.
REQ-008 SHALL have port crotchet  output  7  current crotchet index.
REQ-009 SHALL have port crotchet_pulse  output  1  one-cycle strobe coincident with each new crotchet value.
REQ-010 SHALL have port semi  output  2  semiquaver within crotchet.
REQ-011 SHALL have port semi_pulse  output  1  one-cycle strobe coincident with each new semi value.
REQ-012 SHALL have ports running (1, high in RUN or HOLD) and done (1, high in DONE), both outputs.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HOLD, DONE; all outputs registered.
REQ-014 SHALL, in IDLE or DONE with start=1, enter RUN next cycle with crotchet=0, semi=0, divider=0, crotchet_pulse=1, semi_pulse=1 (one-cycle latency).
REQ-015 SHALL ignore start in RUN and HOLD.
REQ-016 SHALL, in RUN, increment divider each cycle; at divider==CLKS_PER_SEMI-1 wrap divider to 0 and advance semi with semi_pulse=1 in the same cycle the new semi appears.
REQ-017 SHALL, when semi wraps 3->0, advance crotchet with crotchet_pulse=1 in the same cycle as the new value.
REQ-018 SHALL, at end of the last semi of crotchet NUM_CROTCHETS-1, apply end-of-song handling per Configuration.
REQ-019 SHALL, in RUN with hold=1, enter HOLD next cycle; divider, semi, crotchet frozen; no pulses.
REQ-020 SHALL, in HOLD with hold=0, return to RUN and resume divider from its frozen value.
REQ-021 SHALL, on stop=1 in any state, enter IDLE next cycle with crotchet=0, semi=0, divider=0, no pulses.
REQ-022 SHALL give stop priority over start and hold when asserted together.
REQ-023 SHALL never assert crotchet_pulse or semi_pulse for more than one consecutive cycle, except when CLKS_PER_SEMI... minimum 2 guarantees this.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, crotchet=0, semi=0, divider=0, crotchet_pulse=0, semi_pulse=0, running=0, done=0, independent of clk.
REQ-025 SHALL, on reset mid-song, discard all progress; the first action after release requires start.

Configuration
REQ-026 SHALL honour macro BEAT_SEQUENCER_LOOP_EN.
REQ-027 SHALL, with BEAT_SEQUENCER_LOOP_EN defined, wrap crotchet NUM_CROTCHETS-1 -> 0 with crotchet_pulse=1 and stay in RUN.
REQ-028 SHALL, without BEAT_SEQUENCER_LOOP_EN, enter DONE instead: crotchet holds NUM_CROTCHETS-1, semi=3, no pulse, done=1, running=0.

Verification (CLKS_PER_SEMI=4, NUM_CROTCHETS=104)
REQ-029 SHALL cover: rst pulse then start at cycle 10 -> cycle 11 crotchet=0, both pulses=1, running=1; crotchet_pulse again at cycle 27 with crotchet=1.
REQ-030 SHALL cover: full song no loop -> crotchet_pulse count 104, done=1 at cycle start+1+1664, crotchet=103.
REQ-031 SHALL cover: full song with BEAT_SEQUENCER_LOOP_EN -> after crotchet 103, crotchet=0 with crotchet_pulse at cycle start+1+1664, done stays 0.
REQ-032 SHALL cover: hold high 50 cycles mid-crotchet 5 -> no pulses during hold, next crotchet_pulse delayed by exactly 50 cycles.
REQ-033 SHALL cover: start and stop asserted same cycle in RUN -> IDLE, crotchet=0, running=0, no pulse.
REQ-034 SHALL cover: async rst asserted between clock edges at crotchet 40 -> all outputs 0 immediately, start afterwards restarts at crotchet 0.
